// File: rtl/AXI_define.sv
// Shared AXI4 definitions for the CPU-side initiator bridges: bus widths,
// single-beat burst constants, response encodings and the master FSM state type.
package AXI_define;

    localparam int AXI_ID_W   = 4;
    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;

    localparam logic [7:0] AXI_LEN_ONE    = 8'd0;
    localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RADDR,
        S_RDATA,
        S_WREQ,
        S_WRESP,
        S_DONE
    } master_state_t;

endpackage

// File: rtl/cpu_axi_master.sv
// Initiator bridge: converts one CPU memory port into single-beat AXI4 reads and
// writes, stalling the CPU until the response has been collected.
module cpu_axi_master
    import AXI_define::*;
#(
    parameter int ID_W      = AXI_ID_W,
    parameter int ADDR_W    = AXI_ADDR_W,
    parameter int DATA_W    = AXI_DATA_W,
    parameter int MASTER_ID = 0
) (
    input  logic                ACLK,
    input  logic                ARESETn,

    input  logic                req_i,
    input  logic [DATA_W/8-1:0] web_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                stall_o,
    output logic                err_o,

    output logic [ID_W-1:0]     AWID,
    output logic [ADDR_W-1:0]   AWADDR,
    output logic [7:0]          AWLEN,
    output logic [2:0]          AWSIZE,
    output logic [1:0]          AWBURST,
    output logic                AWVALID,
    input  logic                AWREADY,

    output logic [DATA_W-1:0]   WDATA,
    output logic [DATA_W/8-1:0] WSTRB,
    output logic                WLAST,
    output logic                WVALID,
    input  logic                WREADY,

    input  logic [ID_W-1:0]     BID,
    input  logic [1:0]          BRESP,
    input  logic                BVALID,
    output logic                BREADY,

    output logic [ID_W-1:0]     ARID,
    output logic [ADDR_W-1:0]   ARADDR,
    output logic [7:0]          ARLEN,
    output logic [2:0]          ARSIZE,
    output logic [1:0]          ARBURST,
    output logic                ARVALID,
    input  logic                ARREADY,

    input  logic [ID_W-1:0]     RID,
    input  logic [DATA_W-1:0]   RDATA,
    input  logic [1:0]          RRESP,
    input  logic                RLAST,
    input  logic                RVALID,
    output logic                RREADY
);

    master_state_t         state;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W/8-1:0]   strb_q;
    logic                  aw_done;
    logic                  w_done;
    logic                  aw_hs;
    logic                  w_hs;

    // Response IDs and RLAST are not acted on: a single outstanding single-beat
    // transaction makes them redundant.
    logic unused_resp_sigs;
    assign unused_resp_sigs = &{1'b0, BID, RID, RLAST};

    assign AWID    = ID_W'(MASTER_ID);
    assign ARID    = ID_W'(MASTER_ID);
    assign AWLEN   = AXI_LEN_ONE;
    assign ARLEN   = AXI_LEN_ONE;
    assign AWSIZE  = AXI_SIZE_WORD;
    assign ARSIZE  = AXI_SIZE_WORD;
    assign AWBURST = AXI_BURST_INCR;
    assign ARBURST = AXI_BURST_INCR;
    assign AWADDR  = addr_q;
    assign ARADDR  = addr_q;
    assign WDATA   = wdata_q;
    assign WSTRB   = strb_q;
    assign WLAST   = WVALID;

    assign aw_hs = AWVALID && AWREADY;
    assign w_hs  = WVALID && WREADY;

    // Combinational so the CPU is held in the very cycle it raises req_i.
    assign stall_o = (state != S_DONE) && (req_i || (state != S_IDLE));

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            ARVALID <= 1'b0;
            RREADY  <= 1'b0;
            AWVALID <= 1'b0;
            WVALID  <= 1'b0;
            BREADY  <= 1'b0;
            rdata_o <= '0;
            err_o   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_i) begin
                        addr_q  <= addr_i;
                        wdata_q <= wdata_i;
                        strb_q  <= web_i;
                        if (web_i == '0) begin
                            ARVALID <= 1'b1;
                            state   <= S_RADDR;
                        end else begin
                            AWVALID <= 1'b1;
                            WVALID  <= 1'b1;
                            aw_done <= 1'b0;
                            w_done  <= 1'b0;
                            state   <= S_WREQ;
                        end
                    end
                end
                S_RADDR: begin
                    if (ARVALID && ARREADY) begin
                        ARVALID <= 1'b0;
                        RREADY  <= 1'b1;
                        state   <= S_RDATA;
                    end
                end
                S_RDATA: begin
                    if (RVALID) begin
                        rdata_o <= RDATA;
                        err_o   <= (RRESP != RESP_OKAY);
                        RREADY  <= 1'b0;
                        state   <= S_DONE;
                    end
                end
                S_WREQ: begin
                    // Address and data channels complete independently, in either order.
                    if (aw_hs) begin
                        AWVALID <= 1'b0;
                        aw_done <= 1'b1;
                    end
                    if (w_hs) begin
                        WVALID <= 1'b0;
                        w_done <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        BREADY <= 1'b1;
                        state  <= S_WRESP;
                    end
                end
                S_WRESP: begin
                    if (BVALID) begin
                        err_o  <= (BRESP != RESP_OKAY);
                        BREADY <= 1'b0;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_axi_master.sv
// Directed bench for cpu_axi_master: a bench-driven AXI slave, a scoreboard of
// expected CPU-side results and a monitor comparing them in the DONE cycle.
module tb_cpu_axi_master;
    import AXI_define::*;

    localparam int ID_W      = 4;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int MASTER_ID = 0;
    localparam int TMO       = 50;

    logic              ACLK = 1'b0;
    logic              ARESETn;
    logic              req_i;
    logic [3:0]        web_i;
    logic [31:0]       addr_i, wdata_i, rdata_o;
    logic              stall_o, err_o;
    logic [ID_W-1:0]   AWID, ARID, BID, RID;
    logic [31:0]       AWADDR, ARADDR, WDATA, RDATA;
    logic [7:0]        AWLEN, ARLEN;
    logic [2:0]        AWSIZE, ARSIZE;
    logic [1:0]        AWBURST, ARBURST, BRESP, RRESP;
    logic              AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic              ARVALID, ARREADY, RLAST, RVALID, RREADY;
    logic [3:0]        WSTRB;

    always #5 ACLK = ~ACLK;

    cpu_axi_master #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASTER_ID(MASTER_ID)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .req_i(req_i), .web_i(web_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .rdata_o(rdata_o), .stall_o(stall_o), .err_o(err_o),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    typedef struct {
        logic        isRead;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sbQ[$];
    exp_t monExp;
    int   vectors     = 0;
    int   miscompares = 0;
    logic afterDone   = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: the DONE cycle is the only one where the CPU still requests but is not stalled.
    always @(negedge ACLK) begin
        if (ARESETn === 1'b1) begin
            if (afterDone) checkOutput("stall_after_done", 32'(stall_o), 32'(req_i));
            afterDone = 1'b0;
            if (req_i && !stall_o) begin
                afterDone = 1'b1;
                if (sbQ.size() == 0) begin
                    checkOutput("unexpected_done", 32'(1), 32'(0));
                end else begin
                    monExp = sbQ.pop_front();
                    if (monExp.isRead) checkOutput("rdata_o", rdata_o, monExp.data);
                    checkOutput("err_o", 32'(err_o), 32'(monExp.err));
                end
            end
        end
    end

    // VALID must stay up with stable payload until its handshake.
    logic        pRst = 1'b0, pArv = 1'b0, pArr = 1'b0, pAwv = 1'b0, pAwr = 1'b0, pWv = 1'b0, pWr = 1'b0;
    logic [31:0] pAraddr = '0, pAwaddr = '0, pWdata = '0;
    logic [3:0]  pWstrb = '0;
    always @(posedge ACLK) begin
        if (ARESETn === 1'b1 && pRst) begin
            if (pArv && !pArr) begin
                checkOutput("arvalid_hold", 32'(ARVALID), 32'(1));
                checkOutput("araddr_hold", ARADDR, pAraddr);
            end
            if (pAwv && !pAwr) begin
                checkOutput("awvalid_hold", 32'(AWVALID), 32'(1));
                checkOutput("awaddr_hold", AWADDR, pAwaddr);
            end
            if (pWv && !pWr) begin
                checkOutput("wvalid_hold", 32'(WVALID), 32'(1));
                checkOutput("wdata_hold", WDATA, pWdata);
                checkOutput("wstrb_hold", 32'(WSTRB), 32'(pWstrb));
            end
        end
        pRst = ARESETn; pArv = ARVALID; pArr = ARREADY; pAwv = AWVALID; pAwr = AWREADY;
        pWv = WVALID; pWr = WREADY; pAraddr = ARADDR; pAwaddr = AWADDR; pWdata = WDATA; pWstrb = WSTRB;
    end

    always @(posedge ACLK) begin
        if (ARESETn === 1'b1 && RVALID && RREADY)
            assert (RID == ID_W'(MASTER_ID) && RLAST) else $error("[TB] RID/RLAST protocol violation");
        if (ARESETn === 1'b1 && BVALID && BREADY)
            assert (BID == ID_W'(MASTER_ID)) else $error("[TB] BID protocol violation");
    end

    function automatic logic sigOf(input int which);
        case (which)
            0:       return ARVALID;
            1:       return RREADY;
            2:       return AWVALID;
            3:       return BREADY;
            default: return req_i && !stall_o;
        endcase
    endfunction

    task automatic waitSig(input int which, input string name);
        int n = 0;
        while (sigOf(which) !== 1'b1 && n < TMO) begin
            @(negedge ACLK);
            n++;
        end
        if (n >= TMO) checkOutput({"timeout_", name}, 32'(0), 32'(1));
    endtask

    task automatic finishReq(input bit keepReq);
        waitSig(4, "done");
        #1;
        if (!keepReq) begin
            req_i = 1'b0;
            web_i = 4'h0;
        end
    endtask

    task automatic applyRead(input logic [31:0] addr, input int ardly, input int rdly,
                             input logic [31:0] data, input logic [1:0] resp, input bit keepReq);
        exp_t e;
        e.isRead = 1'b1; e.data = data; e.err = (resp != RESP_OKAY);
        sbQ.push_back(e);
        req_i = 1'b1; web_i = 4'h0; addr_i = addr; wdata_i = $urandom;
        waitSig(0, "arvalid");
        checkOutput("araddr", ARADDR, addr);
        checkOutput("ar_attrs", {12'h0, ARID, ARLEN, ARSIZE, ARBURST}, {12'h0, 4'h0, 8'h00, 3'b010, 2'b01});
        repeat (ardly) @(negedge ACLK);
        ARREADY = 1'b1;
        @(negedge ACLK);
        ARREADY = 1'b0;
        waitSig(1, "rready");
        repeat (rdly) @(negedge ACLK);
        RVALID = 1'b1; RDATA = data; RRESP = resp; RLAST = 1'b1; RID = '0;
        @(negedge ACLK);
        RVALID = 1'b0; RDATA = '0; RRESP = 2'b00;
        finishReq(keepReq);
    endtask

    task automatic applyWrite(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] data,
                              input int awdly, input int wdly, input int bdly,
                              input logic [1:0] resp, input bit keepReq);
        exp_t e;
        int awCnt = 0, wCnt = 0, bCnt = 0;
        int last = (awdly > wdly) ? awdly : wdly;
        e.isRead = 1'b0; e.data = '0; e.err = (resp != RESP_OKAY);
        sbQ.push_back(e);
        req_i = 1'b1; web_i = strb; addr_i = addr; wdata_i = data;
        waitSig(2, "awvalid");
        checkOutput("wvalid_with_awvalid", 32'(WVALID), 32'(1));
        checkOutput("awaddr", AWADDR, addr);
        checkOutput("wdata", WDATA, data);
        checkOutput("wstrb", 32'(WSTRB), 32'(strb));
        checkOutput("wlast", 32'(WLAST), 32'(1));
        for (int c = 0; c <= last; c++) begin
            if (AWVALID) awCnt++;
            if (WVALID) wCnt++;
            AWREADY = (c == awdly);
            WREADY  = (c == wdly);
            @(negedge ACLK);
        end
        AWREADY = 1'b0; WREADY = 1'b0;
        checkOutput("aw_cycles", 32'(awCnt), 32'(awdly + 1));
        checkOutput("w_cycles", 32'(wCnt), 32'(wdly + 1));
        waitSig(3, "bready");
        for (int c = 0; c <= bdly; c++) begin
            if (BREADY) bCnt++;
            BVALID = (c == bdly); BRESP = resp; BID = '0;
            @(negedge ACLK);
        end
        BVALID = 1'b0; BRESP = 2'b00;
        checkOutput("bready_cycles", 32'(bCnt), 32'(bdly + 1));
        finishReq(keepReq);
    endtask

    initial begin
        ARESETn = 1'b0; req_i = 1'b0; web_i = '0; addr_i = '0; wdata_i = '0;
        AWREADY = 1'b0; WREADY = 1'b0; BID = '0; BRESP = '0; BVALID = 1'b0;
        ARREADY = 1'b0; RID = '0; RDATA = '0; RRESP = '0; RLAST = 1'b0; RVALID = 1'b0;
        repeat (2) @(negedge ACLK);
        checkOutput("reset_valids", {27'h0, ARVALID, RREADY, AWVALID, WVALID, BREADY}, 32'h0);
        checkOutput("reset_rdata", rdata_o, 32'h0);
        checkOutput("reset_err_stall", {30'h0, err_o, stall_o}, 32'h0);
        ARESETn = 1'b1;
        @(negedge ACLK);

        applyRead(32'h0000_0010, 0, 2, 32'hDEAD_BEEF, RESP_OKAY, 1'b0);
        @(negedge ACLK);
        applyWrite(32'h0001_0004, 4'b0011, 32'h1234_5678, 0, 2, 1, RESP_OKAY, 1'b0);
        @(negedge ACLK);
        applyWrite(32'h0000_0100, 4'b1111, 32'hA5A5_5A5A, 2, 0, 0, RESP_OKAY, 1'b0);
        @(negedge ACLK);
        applyWrite(32'h0000_0200, 4'b1000, 32'hCAFE_F00D, 1, 1, 2, RESP_OKAY, 1'b0);
        @(negedge ACLK);
        applyRead(32'h2000_0000, 1, 0, 32'h0000_0000, RESP_DECERR, 1'b0);
        @(negedge ACLK);

        applyRead(32'h0000_0020, 1, 1, 32'h1111_1111, RESP_OKAY, 1'b1);
        applyWrite(32'h0000_0024, 4'b0100, 32'h0055_0000, 1, 0, 0, RESP_SLVERR, 1'b1);
        applyRead(32'h0000_0028, 0, 0, 32'h0BAD_F00D, RESP_OKAY, 1'b0);
        @(negedge ACLK);

        // Reset while waiting for the write response.
        req_i = 1'b1; web_i = 4'hF; addr_i = 32'h0000_0300; wdata_i = 32'h7777_8888;
        waitSig(2, "awvalid");
        AWREADY = 1'b1; WREADY = 1'b1;
        @(negedge ACLK);
        AWREADY = 1'b0; WREADY = 1'b0;
        checkOutput("bready_before_reset", 32'(BREADY), 32'(1));
        ARESETn = 1'b0;
        #1;
        checkOutput("reset_mid_valids", {29'h0, AWVALID, WVALID, BREADY}, 32'h0);
        checkOutput("reset_mid_stall_req", 32'(stall_o), 32'(1));
        checkOutput("reset_mid_rdata_err", {rdata_o[30:0], err_o}, 32'h0);
        req_i = 1'b0; web_i = 4'h0;
        #1;
        checkOutput("reset_mid_stall_noreq", 32'(stall_o), 32'(0));
        @(negedge ACLK);
        ARESETn = 1'b1;
        @(negedge ACLK);

        applyRead(32'h0000_0040, 0, 0, 32'hFACE_0001, RESP_OKAY, 1'b0);
        repeat (2) @(negedge ACLK);
        checkOutput("scoreboard_drained", 32'(sbQ.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
